// File: rtl/axis_s_fifo.sv
// AXI-Stream slave with a small first-word-fall-through buffer, local pop port,
// registered backpressure and a count of completed packets.
module axis_s_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset_n,
  input  logic              tvalid,
  output logic              tready,
  input  logic              tlast,
  input  logic [DATA_W-1:0] tdata,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       level,
  output logic [15:0]       pkt_count,
  output logic              received,
  output logic              rd_err
);

  logic [DATA_W:0] mem [DEPTH];
  logic [DATA_W:0] head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic [AW:0]     level_next;

  assign push = tvalid & tready;
  assign pop  = rd_en & ~empty;

  always_comb begin
    level_next = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // Storage has no reset; only the pointers and flags define what is valid.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= {tlast, tdata};
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      tready    <= 1'b0;
      pkt_count <= '0;
      received  <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level    <= level_next;
      empty    <= (level_next == '0);
      full     <= (level_next == (AW+1)'(DEPTH));
      // tready is looked ahead from level_next so a full buffer never takes a beat.
      tready   <= (level_next < (AW+1)'(DEPTH));
      received <= push & tlast;
      if (push && tlast) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (rd_en && empty) begin
        rd_err <= 1'b1;
      end
    end
  end

  assign head    = mem[rd_ptr];
  assign rd_data = empty ? '0 : head[DATA_W-1:0];
  assign rd_last = empty ? 1'b0 : head[DATA_W];

endmodule

// File: tb/tb_axis_s_fifo.sv
// Bench for axis_s_fifo: drives directed and random traffic and compares every
// output against a queue-based model of the buffer.
module tb_axis_s_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int AW     = $clog2(DEPTH);
  localparam int VW     = DATA_W + 1 + 1 + 1 + (AW + 1) + 1 + 16 + 1 + 1;

  logic              aclk = 1'b0;
  logic              areset_n = 1'b0;
  logic              tvalid = 1'b0;
  logic              tready;
  logic              tlast = 1'b0;
  logic [DATA_W-1:0] tdata = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              empty;
  logic              full;
  logic [AW:0]       level;
  logic [15:0]       pkt_count;
  logic              received;
  logic              rd_err;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t       q[$];
  logic        m_tready;
  logic [15:0] m_pkt;
  logic        m_received;
  logic        m_rd_err;

  axis_s_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset_n(areset_n), .tvalid(tvalid), .tready(tready),
    .tlast(tlast), .tdata(tdata), .rd_en(rd_en), .rd_data(rd_data),
    .rd_last(rd_last), .empty(empty), .full(full), .level(level),
    .pkt_count(pkt_count), .received(received), .rd_err(rd_err)
  );

  always #5 aclk = ~aclk;

  task automatic model_reset();
    q.delete();
    m_tready   = 1'b0;
    m_pkt      = '0;
    m_received = 1'b0;
    m_rd_err   = 1'b0;
  endtask

  function automatic logic [VW-1:0] obs_vec();
    return {rd_data, rd_last, empty, full, level, tready, pkt_count, received, rd_err};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    beat_t h;
    h = (q.size() != 0) ? q[0] : '0;
    return {h.data, h.last, (q.size() == 0), (q.size() == DEPTH), (AW+1)'(q.size()),
            m_tready, m_pkt, m_received, m_rd_err};
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, settle #1.
  task automatic step(input logic v, input logic l, input logic [DATA_W-1:0] d, input logic r);
    bit do_push;
    bit do_pop;
    tvalid = v; tlast = l; tdata = d; rd_en = r;
    @(posedge aclk);
    do_push = v && m_tready;
    do_pop  = r && (q.size() != 0);
    if (r && q.size() == 0) m_rd_err = 1'b1;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back({l, d});
    m_received = do_push && l;
    if (do_push && l) m_pkt = m_pkt + 16'd1;
    m_tready = (q.size() < DEPTH);
    #1;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    tvalid = 1'b0; tlast = 1'b0; tdata = '0; rd_en = 1'b0;
    model_reset();
    @(posedge aclk);
    #1;
    areset_n = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if (obs_vec() !== exp_vec())
      $display("[TB] FAIL reset_values: got %h expected %h", obs_vec(), exp_vec());
    else passed++;
    areset_n = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (tready !== 1'b1 || rd_err !== 1'b0)
      $display("[TB] FAIL reset_release: got tready=%b rd_err=%b expected tready=1 rd_err=0", tready, rd_err);
    else passed++;
  endtask

  task automatic test_single_beat();
    step(1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
    checks++;
    if ({rd_data, rd_last, level, pkt_count, received} !== {32'hDEADBEEF, 1'b1, 3'd1, 16'd1, 1'b1})
      $display("[TB] FAIL single_push: got data=%h last=%b level=%0d pkt=%0d rcv=%b expected deadbeef 1 1 1 1",
               rd_data, rd_last, level, pkt_count, received);
    else passed++;
    step(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec())
      $display("[TB] FAIL single_hold: got %h expected %h", obs_vec(), exp_vec());
    else passed++;
    step(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (empty !== 1'b1 || rd_data !== '0 || obs_vec() !== exp_vec())
      $display("[TB] FAIL single_pop: got %h expected %h", obs_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_fill_backpressure();
    logic [DATA_W-1:0] val;
    bit accepted;
    val = 1;
    for (int c = 0; c < 6; c++) begin
      accepted = m_tready;
      step(1'b1, 1'b0, val, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("[TB] FAIL fill_cycle%0d: got %h expected %h", c, obs_vec(), exp_vec());
      else passed++;
      if (accepted) val++;
    end
    checks++;
    if (full !== 1'b1 || tready !== 1'b0 || val !== 32'd5)
      $display("[TB] FAIL fill_full: got full=%b tready=%b next=%0d expected 1 0 5", full, tready, val);
    else passed++;
    step(1'b1, 1'b0, 32'd5, 1'b1);
    checks++;
    if (tready !== 1'b1 || level !== 3'd3)
      $display("[TB] FAIL fill_pop_ready: got tready=%b level=%0d expected 1 3", tready, level);
    else passed++;
    step(1'b1, 1'b0, 32'd5, 1'b0);
    checks++;
    if (level !== 3'd4 || full !== 1'b1)
      $display("[TB] FAIL fill_held_beat: got level=%0d full=%b expected 4 1", level, full);
    else passed++;
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      checks++;
      if (rd_data !== DATA_W'(i) || obs_vec() !== exp_vec())
        $display("[TB] FAIL fill_order%0d: got %h expected data %0d", i, rd_data, i);
      else passed++;
      step(1'b0, 1'b0, '0, 1'b1);
    end
    checks++;
    if (empty !== 1'b1 || rd_err !== 1'b0)
      $display("[TB] FAIL fill_drained: got empty=%b rd_err=%b expected 1 0", empty, rd_err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, DATA_W'(i), (i > 0));
      checks++;
      if (level > 1 || rd_data !== DATA_W'(i) || obs_vec() !== exp_vec())
        $display("[TB] FAIL stream_beat%0d: got level=%0d data=%0d expected level<=1 data=%0d",
                 i, level, rd_data, i);
      else passed++;
    end
    step(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (pkt_count !== 16'd20 || empty !== 1'b1 || rd_err !== 1'b0)
      $display("[TB] FAIL stream_end: got pkt=%0d empty=%b rd_err=%b expected 20 1 0", pkt_count, empty, rd_err);
    else passed++;
  endtask

  task automatic test_rd_err();
    step(1'b1, 1'b0, 32'hA5, 1'b1);
    checks++;
    if (rd_err !== 1'b1 || level !== 3'd1 || rd_data !== 32'hA5)
      $display("[TB] FAIL rderr_set: got rd_err=%b level=%0d data=%h expected 1 1 a5", rd_err, level, rd_data);
    else passed++;
    for (int i = 0; i < 150; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 1)));
      checks++;
      if (obs_vec() !== exp_vec())
        $display("[TB] FAIL random%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else passed++;
    end
    do_reset();
    checks++;
    if (rd_err !== 1'b0 || obs_vec() !== exp_vec())
      $display("[TB] FAIL rderr_cleared: got %h expected %h", obs_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_pkt_wrap();
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      step(1'b1, 1'b1, DATA_W'(i), (i > 0));
    end
    checks++;
    if (pkt_count !== 16'hFFFF || obs_vec() !== exp_vec())
      $display("[TB] FAIL wrap_preload: got pkt=%0d expected 65535", pkt_count);
    else passed++;
    step(1'b1, 1'b1, 32'h1234, 1'b1);
    checks++;
    if (pkt_count !== 16'd0 || received !== 1'b1 || obs_vec() !== exp_vec())
      $display("[TB] FAIL wrap_zero: got pkt=%0d rcv=%b expected 0 1", pkt_count, received);
    else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DATA_W'(100 + i), 1'b0);
    tvalid = 1'b1; tdata = 32'h77;
    #3;
    areset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== exp_vec())
      $display("[TB] FAIL reset_mid_async: got %h expected %h", obs_vec(), exp_vec());
    else passed++;
    @(posedge aclk);
    #1;
    checks++;
    if (obs_vec() !== exp_vec())
      $display("[TB] FAIL reset_mid_held: got %h expected %h", obs_vec(), exp_vec());
    else passed++;
    areset_n = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (tready !== 1'b1 || empty !== 1'b1 || obs_vec() !== exp_vec())
      $display("[TB] FAIL reset_mid_release: got %h expected %h", obs_vec(), exp_vec());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_fill_backpressure();
    test_back_to_back();
    test_rd_err();
    test_pkt_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axis_s_fifo.md
# axis_s_fifo

AXI-Stream slave that sits directly downstream of the single-beat AXIS master (`axis_m`) and consumes its stream. It buffers accepted beats in a small first-word-fall-through FIFO and applies backpressure through `tready` when full. A local read port pops buffered words, and the block counts completed packets (beats with `tlast`). All logic runs in one clock domain.

## Interface
Parameters:
- DATA_W, 32, stream and read data width
- DEPTH, 4, FIFO depth in words; power of two, ≥2; AW = log2(DEPTH)

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset_n  in  1  reset, asynchronous, active-low
- tvalid  in  1  upstream beat valid
- tready  out  1  slave ready, registered
- tlast  in  1  last beat of packet
- tdata  in  DATA_W  beat data
- rd_en  in  1  pop request for head word
- rd_data  out  DATA_W  head word (FWFT); 0 when empty
- rd_last  out  1  tlast flag stored with head word; 0 when empty
- empty  out  1  FIFO holds no words
- full  out  1  FIFO holds DEPTH words
- level  out  AW+1  words currently stored, 0..DEPTH
- pkt_count  out  16  number of accepted `tlast` beats, modulo 2^16
- received  out  1  one-cycle pulse when a `tlast` beat is accepted
- rd_err  out  1  sticky flag: `rd_en` while empty

## Operation
- Reset values: tready=0, empty=1, full=0, level=0, rd_data=0, rd_last=0, pkt_count=0, received=0, rd_err=0. Storage contents are don't-care.
- Storage is DEPTH × (DATA_W+1) entries holding {tlast, tdata}, addressed by wr_ptr and rd_ptr (AW bits each). Both pointers wrap from DEPTH-1 to 0.
- push = tvalid & tready. On push, write {tlast, tdata} at wr_ptr and increment wr_ptr.
- pop = rd_en & ~empty. On pop, increment rd_ptr.
- level_next = level + push − pop. Push and pop together leave level unchanged.
- empty and full are registered and derived from level_next: empty = (level_next==0), full = (level_next==DEPTH).
- tready register: next value = (level_next < DEPTH). The `tvalid`→`tready` path is never combinational.
- When full, tready=0, so push is impossible and no beat is dropped. The master holds tvalid and tdata until tready returns.
- When empty, rd_en is ignored and sets rd_err. rd_err stays set until reset.
- rd_data and rd_last show the storage entry at rd_ptr whenever ~empty; both are forced to 0 when empty.
- On push with tlast=1: pkt_count increments, wrapping from 0xFFFF to 0, and `received` is 1 for the following cycle. Otherwise `received` is 0.
- tlast=0 beats are stored and popped normally; only tlast beats are counted.
- Reset asserted mid-operation clears all state immediately, including any word being accepted on that edge. Buffered data is lost.

## Timing
- Fall-through latency: a beat accepted at edge N is on rd_data, with empty=0, from edge N up to the next edge. It can be popped at edge N+1.
- Back-to-back: one push per cycle while not full, and one pop per cycle while not empty, for full throughput.
- After areset_n deasserts, tready rises at the first aclk edge.
- Filling the last slot at edge N makes full=1 and tready=0 from edge N. A pop at edge M while full makes tready=1 from edge M.
- Simultaneous push and pop at level DEPTH cannot occur. At level 0, a simultaneous push and rd_en gives: push accepted, pop ignored, rd_err set.
- pkt_count and received update on the same edge as the push.

## Test plan
- Reset, then release: all outputs at reset values; tready=1 after the first edge; rd_err=0.
- Single beat 0xDEADBEEF with tlast=1, no reads: next cycle rd_data=0xDEADBEEF, rd_last=1, level=1, pkt_count=1, received pulses one cycle. Pop: empty=1, rd_data=0.
- Push 0x1..0x5 back-to-back with DEPTH=4 and rd_en=0: 0x1–0x4 accepted, tready=0 with full=1 after the 4th, 0x5 held. Pop once: 0x5 accepted next edge. Pops then return 0x1..0x5 in order.
- Continuous push and pop, 20 beats with values 0..19: level stays ≤1, order preserved, pointer wrap-around exercised, pkt_count=20.
- rd_en pulsed while empty: rd_err=1 and stays 1 through later valid traffic until reset.
- Preload pkt_count near wrap (65535 tlast beats, or force): next tlast beat gives 0. Assert areset_n low mid-burst: outputs immediately return to reset values.
